menu_input_ctrl: RTL and testbench

- Front end for the game menu: takes three raw, bouncing, asynchronous push-buttons (up, down, select).
- Produces clean single-cycle `top`, `bottom` and `select` command pulses for the menu FSM.
- Per-button 2-FF synchronisers, counter-based debouncing and auto-repeat while up/down are held.
- Output arbitration guarantees at most one command per cycle; the menu logic downstream therefore needs no debounce counters of its own.

---
 rtl/menu_pkg.sv | 19 +
 rtl/button_debounce.sv | 58 +++++
 rtl/menu_input_ctrl.sv | 146 ++++++++++++++
 tb/tb_menu_input_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared types and default timing for the menu push-button front end.
package menu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } repeat_state_t;

  localparam int CLK_FREQ_HZ          = 65_000_000;
  localparam int DEBOUNCE_CYCLES_DFLT = 650_000;     // 10 ms
  localparam int HOLD_CYCLES_DFLT     = 32_500_000;  // 0.5 s
  localparam int REPEAT_CYCLES_DFLT   = 13_000_000;  // 0.2 s

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-FF synchroniser, counter debouncer, stable level and a
// registered one-cycle press event on the stable 0->1 transition.
module button_debounce
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any sample agreeing with the stable level restarts the count, so bounces
  // never accumulate towards a level change.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
        press_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/menu_input_ctrl.sv
// Menu button front end: three debounced buttons, hold/auto-repeat for up and
// down, and a select > up > down arbiter producing registered one-cycle commands.
module menu_input_ctrl
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DFLT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_sel,
  input  logic menu_active,
  output logic top,
  output logic bottom,
  output logic select
);

  localparam int RPT_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  // Channel 0 is up, channel 1 is down.
  logic [1:0] stable;
  logic [1:0] press;
  logic       sel_stable;
  logic       sel_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_up),
    .stable_o (stable[0]),
    .press_o  (press[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_down),
    .stable_o (stable[1]),
    .press_o  (press[1])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_sel),
    .stable_o (sel_stable),
    .press_o  (sel_press)
  );

  repeat_state_t    state_q [2];
  repeat_state_t    state_d [2];
  logic [RPT_W-1:0] rcnt_q  [2];
  logic [RPT_W-1:0] rcnt_d  [2];
  logic [1:0]       req;
  logic             req_sel;
  logic             top_q, top_d;
  logic             bottom_q, bottom_d;
  logic             select_q, select_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
      top_q    <= 1'b0;
      bottom_q <= 1'b0;
      select_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
      top_q    <= top_d;
      bottom_q <= bottom_d;
      select_q <= select_d;
    end
  end

  // The repeat FSMs run independently of arbitration; a lost request is
  // simply gone and the cadence continues.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      req[i]     = 1'b0;
      if (!menu_active) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (press[i]) begin
              req[i]     = 1'b1;
              state_d[i] = HOLD;
              rcnt_d[i]  = '0;
            end
          end
          HOLD: begin
            if (!stable[i]) begin
              state_d[i] = IDLE;
              rcnt_d[i]  = '0;
            end else if (rcnt_q[i] == RPT_W'(HOLD_CYCLES - 1)) begin
              req[i]     = 1'b1;
              state_d[i] = REPEAT;
              rcnt_d[i]  = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (!stable[i]) begin
              state_d[i] = IDLE;
              rcnt_d[i]  = '0;
            end else if (rcnt_q[i] == RPT_W'(REPEAT_CYCLES - 1)) begin
              req[i]    = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    req_sel  = menu_active & sel_press & sel_stable;
    select_d = req_sel;
    top_d    = req[0] & ~req_sel;
    bottom_d = req[1] & ~req_sel & ~req[0];
  end

  assign top    = top_q;
  assign bottom = bottom_q;
  assign select = select_q;

endmodule

// File: tb/tb_menu_input_ctrl.sv
// Directed and randomised bench for menu_input_ctrl against a windowed,
// event-time reference model (DEBOUNCE=4, HOLD=20, REPEAT=8).
module tb_menu_input_ctrl;

  localparam int D    = 4;
  localparam int H    = 20;
  localparam int R    = 8;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst, up, dn, sel, menu;
  logic top, bottom, select;

  menu_input_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (up),
    .btn_down    (dn),
    .btn_sel     (sel),
    .menu_active (menu),
    .top         (top),
    .bottom      (bottom),
    .select      (select)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int top_t[$];
  int bot_t[$];
  int sel_t[$];

  // Reference model state: raw sample history since reset release, level
  // decisions by window inspection, and repeat behaviour as scheduled times.
  bit   raw_h [0:2][0:MAXE-1];
  int   e;
  logic stable_m [3];
  int   last_flip [3];
  logic press_m [3];
  logic armed [2];
  int   next_t [2];
  logic exp_top, exp_bot, exp_sel;

  task automatic model_reset();
    e = 0;
    for (int b = 0; b < 3; b++) begin
      stable_m[b]  = 1'b0;
      last_flip[b] = 0;
      press_m[b]   = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      armed[i]  = 1'b0;
      next_t[i] = 0;
    end
    exp_top = 1'b0;
    exp_bot = 1'b0;
    exp_sel = 1'b0;
  endtask

  // Synchronised value visible after edge j: the raw sample of edge j-1.
  function automatic bit sync_after(input int b, input int j);
    return (j >= 2) ? raw_h[b][j-1] : 1'b0;
  endfunction

  task automatic model_step();
    logic rs;
    logic rq [2];
    bit   all_diff;
    if (!rst) begin
      model_reset();
      return;
    end
    e++;
    raw_h[0][e] = up;
    raw_h[1][e] = dn;
    raw_h[2][e] = sel;
    rs = menu && press_m[2];
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0;
      if (!menu) armed[i] = 1'b0;
      else if (armed[i]) begin
        if (!stable_m[i]) armed[i] = 1'b0;
        else if (e == next_t[i]) begin
          rq[i]     = 1'b1;
          next_t[i] = e + R;
        end
      end else if (press_m[i]) begin
        rq[i]     = 1'b1;
        armed[i]  = 1'b1;
        next_t[i] = e + H;
      end
    end
    exp_sel = rs;
    exp_top = rq[0] && !rs;
    exp_bot = rq[1] && !rs && !rq[0];
    for (int b = 0; b < 3; b++) begin
      press_m[b] = 1'b0;
      if (e - last_flip[b] >= D) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++)
          if (sync_after(b, e - k) == stable_m[b]) all_diff = 1'b0;
        if (all_diff) begin
          stable_m[b]  = ~stable_m[b];
          last_flip[b] = e;
          press_m[b]   = stable_m[b];
        end
      end
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, ex);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
    end
  endtask

  task automatic chk_times(input string tag, input int got[$], input int want[$]);
    chk_int({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk_int($sformatf("%s_t%0d", tag, i), (i < got.size()) ? got[i] : -1, want[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk_bit("top", top, exp_top);
    chk_bit("bottom", bottom, exp_bot);
    chk_bit("select", select, exp_sel);
    chk_bit("excl", (32'(top) + 32'(bottom) + 32'(select)) <= 1, 1'b1);
    if (top)    top_t.push_back(cyc);
    if (bottom) bot_t.push_back(cyc);
    if (select) sel_t.push_back(cyc);
  endtask

  task automatic start_scn();
    cyc = 0;
    top_t.delete();
    bot_t.delete();
    sel_t.delete();
  endtask

  initial begin
    int   hold_left [3];
    logic lvl [3];

    rst = 1'b0; up = 1'b0; dn = 1'b0; sel = 1'b0; menu = 1'b1;
    model_reset();
    #3;
    chk_bit("rst_top", top, 1'b0);
    chk_bit("rst_bottom", bottom, 1'b0);
    chk_bit("rst_select", select, 1'b0);
    up = 1'b1; sel = 1'b1;
    repeat (8) tick();
    up = 1'b0; sel = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();

    // Clean up press, held 12 cycles
    start_scn();
    up = 1'b1;
    repeat (12) tick();
    up = 1'b0;
    repeat (20) tick();
    chk_times("s1_top", top_t, '{7});
    chk_int("s1_bottom_count", bot_t.size(), 0);
    chk_int("s1_select_count", sel_t.size(), 0);

    // Bouncing down, then a clean hold
    start_scn();
    for (int k = 0; k < 6; k++) begin
      dn = (k % 2 == 0);
      repeat (2) tick();
    end
    dn = 1'b1;
    repeat (15) tick();
    dn = 1'b0;
    repeat (20) tick();
    chk_times("s2_bottom", bot_t, '{19});

    // Long hold with auto-repeat
    start_scn();
    up = 1'b1;
    repeat (60) tick();
    up = 1'b0;
    repeat (20) tick();
    chk_times("s3_top", top_t, '{7, 27, 35, 43, 51, 59});

    // Select and up together
    start_scn();
    up = 1'b1; sel = 1'b1;
    repeat (36) tick();
    up = 1'b0; sel = 1'b0;
    repeat (20) tick();
    chk_times("s4_select", sel_t, '{7});
    chk_times("s4_top", top_t, '{27, 35});

    // Menu inactive while pressing, then release and re-press
    start_scn();
    menu = 1'b0; up = 1'b1;
    repeat (15) tick();
    menu = 1'b1;
    repeat (15) tick();
    up = 1'b0;
    repeat (10) tick();
    chk_int("s5_hidden_top_count", top_t.size(), 0);
    start_scn();
    up = 1'b1;
    repeat (12) tick();
    up = 1'b0;
    repeat (20) tick();
    chk_times("s5_top", top_t, '{7});

    // Asynchronous reset during a held down, released with the button held
    start_scn();
    dn = 1'b1;
    repeat (27) tick();
    chk_times("s6_pre_bottom", bot_t, '{7, 27});
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk_bit("s6_async_bottom", bottom, exp_bot);
    chk_bit("s6_async_top", top, exp_top);
    repeat (3) tick();
    rst = 1'b1;
    start_scn();
    repeat (35) tick();
    dn = 1'b0;
    repeat (20) tick();
    chk_times("s6_bottom", bot_t, '{7, 27, 35});

    // Randomised bouncing buttons and menu visibility
    for (int b = 0; b < 3; b++) begin
      hold_left[b] = 0;
      lvl[b]       = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          lvl[b] = 1'($urandom_range(1, 0));
          hold_left[b] = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 1))
                                                     : int'($urandom_range(70, 5));
        end
        hold_left[b]--;
      end
      up  = lvl[0];
      dn  = lvl[1];
      sel = lvl[2];
      if (menu) begin
        if ($urandom_range(299, 0) == 0) menu = 1'b0;
      end else begin
        if ($urandom_range(39, 0) == 0) menu = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
